eth_tx_scheduler: RTL

// Packet-level controller for the RMII dibit serializer (2 bits/cycle, address header then payload).

---
 rtl/eth_tx_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/eth_tx_scheduler.sv
// eth_tx_scheduler: packet-level arbiter for the RMII dibit serializer.
// Picks a video row or an audio block as the next packet, starts the serializer,
// waits for completion (with a timeout), enforces the inter-packet gap and keeps
// track of which video row goes next.
module eth_tx_scheduler #(
    parameter int PIXELS_PER_ROW = 320,
    parameter int ROWS           = 240,
    parameter int AUDIO_BYTES    = 256,
    parameter int AUDIO_LEVEL_W  = 10,
    parameter int IFG_CYCLES     = 48,
    parameter int TIMEOUT_CYC    = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     frame_start,
    input  logic                     row_ready,
    input  logic [AUDIO_LEVEL_W-1:0] audio_level,
    input  logic                     tx_done,
    output logic                     tx_start,
    output logic                     tx_kind,
    output logic [16:0]              tx_base_addr,
    output logic [8:0]               tx_len,
    output logic                     sched_stall,
    output logic [7:0]               row_idx,
    output logic                     frame_done,
    output logic                     err_timeout
);

    // One counter is shared between the timeout (WAIT_DONE) and the gap (GAP);
    // the two are never active at the same time.
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    localparam logic [1:0] S_ARB       = 2'd0;
    localparam logic [1:0] S_START     = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_GAP       = 2'd3;

    logic [1:0]       state_q,      state_d;
    logic             kind_q,       kind_d;
    logic [16:0]      base_q,       base_d;
    logic [8:0]       len_q,        len_d;
    logic [7:0]       row_q,        row_d;
    logic             last_kind_q,  last_kind_d;
    logic             frame_pend_q, frame_pend_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;

    logic       vreq;
    logic       areq;
    logic       grant;
    logic       grant_audio;
    logic [7:0] row_eff;
    logic       done_now;
    logic       frame_done_w;
    logic       timeout_w;

    // Next-state logic: arbitration, packet tracking, timeout/gap counting, row bookkeeping.
    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        base_d       = base_q;
        len_d        = len_q;
        row_d        = row_q;
        last_kind_d  = last_kind_q;
        frame_pend_d = frame_pend_q | frame_start;
        cnt_d        = cnt_q;
        grant        = 1'b0;
        grant_audio  = 1'b0;
        row_eff      = row_q;
        done_now     = 1'b0;
        frame_done_w = 1'b0;
        timeout_w    = 1'b0;

        vreq = enable & row_ready;
        areq = enable & ({{(32-AUDIO_LEVEL_W){1'b0}}, audio_level} >= 32'(AUDIO_BYTES));

        case (state_q)
            S_ARB: begin
                // A pending frame start restarts the row count before any grant this cycle.
                if (frame_pend_q) begin
                    row_eff      = 8'd0;
                    row_d        = 8'd0;
                    frame_pend_d = frame_start;
                end
                if (vreq && areq) begin
                    grant       = 1'b1;
                    grant_audio = ~last_kind_q;
                end else if (vreq) begin
                    grant = 1'b1;
                end else if (areq) begin
                    grant       = 1'b1;
                    grant_audio = 1'b1;
                end
                if (grant) begin
                    kind_d      = grant_audio;
                    last_kind_d = grant_audio;
                    len_d       = grant_audio ? 9'(AUDIO_BYTES) : 9'(PIXELS_PER_ROW);
                    base_d      = grant_audio ? 17'd0 : 17'(row_eff) * 17'(PIXELS_PER_ROW);
                    state_d     = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT_DONE;
                if (tx_done) begin
                    done_now = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    done_now = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_w = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(IFG_CYCLES - 1)) begin
                    state_d = S_ARB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_ARB;
            end
        endcase

        // A completed video packet advances the row; the last row wraps and marks the frame.
        if (done_now) begin
            state_d = S_GAP;
            cnt_d   = '0;
            if (!kind_q) begin
                if (row_q == 8'(ROWS - 1)) begin
                    row_d        = 8'd0;
                    frame_done_w = 1'b1;
                end else begin
                    row_d = row_q + 8'd1;
                end
            end
        end
    end

    // State and packet registers, asynchronously cleared; audio counts as last kind so video wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_ARB;
            kind_q       <= 1'b0;
            base_q       <= 17'd0;
            len_q        <= 9'd0;
            row_q        <= 8'd0;
            last_kind_q  <= 1'b1;
            frame_pend_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            base_q       <= base_d;
            len_q        <= len_d;
            row_q        <= row_d;
            last_kind_q  <= last_kind_d;
            frame_pend_q <= frame_pend_d;
            cnt_q        <= cnt_d;
        end
    end

    assign tx_start     = (state_q == S_START);
    assign sched_stall  = (state_q == S_ARB) || (state_q == S_GAP);
    assign tx_kind      = kind_q;
    assign tx_base_addr = base_q;
    assign tx_len       = len_q;
    assign row_idx      = row_q;
    assign frame_done   = frame_done_w;
    assign err_timeout  = timeout_w;

endmodule
